// File: rtl/mano_pkg.sv
// Shared types and encodings for the basic-computer instruction sequencer.
// Opcode, register-reference bit positions and datapath select encodings live here.
package mano_pkg;

  typedef enum logic [3:0] {
    S_CLR,
    S_F0,
    S_F1,
    S_DEC,
    S_IND,
    S_EX0,
    S_EX1,
    S_EX2,
    S_RR,
    S_HALT
  } state_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_RR  = 3'd7;

  localparam int RR_CLA = 11;
  localparam int RR_CLE = 10;
  localparam int RR_CMA = 9;
  localparam int RR_CME = 8;
  localparam int RR_CIR = 7;
  localparam int RR_CIL = 6;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_SZE = 1;
  localparam int RR_HLT = 0;

  localparam logic [1:0] AC_OP_AND = 2'd0;
  localparam logic [1:0] AC_OP_ADD = 2'd1;
  localparam logic [1:0] AC_OP_LDA = 2'd2;

  localparam logic [1:0] AR_SEL_PC  = 2'd0;
  localparam logic [1:0] AR_SEL_IR  = 2'd1;
  localparam logic [1:0] AR_SEL_BUS = 2'd2;

  localparam logic WR_SEL_DR = 1'b0;
  localparam logic WR_SEL_PC = 1'b1;

  // Instructions that fetch their operand into DR before executing.
  function automatic logic reads_operand(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_LDA) || (op == OP_ISZ);
  endfunction

  function automatic logic [1:0] ac_op_of(input logic [2:0] op);
    case (op)
      OP_ADD:  return AC_OP_ADD;
      OP_LDA:  return AC_OP_LDA;
      default: return AC_OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/mano_rr_decode.sv
// Register-reference decode: each set IR bit 11..0 becomes its own strobe while enabled,
// so multi-operation words (e.g. CLA+CIL) fire together in a single cycle.
module mano_rr_decode
  import mano_pkg::*;
(
  input  logic        en_i,
  input  logic [11:0] ir_i,
  output logic [6:0]  rr_ctl_o,
  output logic        spa_o,
  output logic        sna_o,
  output logic        sza_o,
  output logic        sze_o,
  output logic        hlt_o
);

  assign rr_ctl_o = en_i ? {ir_i[RR_CLA], ir_i[RR_CLE], ir_i[RR_CMA], ir_i[RR_CME],
                            ir_i[RR_CIR], ir_i[RR_CIL], ir_i[RR_INC]} : 7'd0;
  assign spa_o    = en_i & ir_i[RR_SPA];
  assign sna_o    = en_i & ir_i[RR_SNA];
  assign sza_o    = en_i & ir_i[RR_SZA];
  assign sze_o    = en_i & ir_i[RR_SZE];
  assign hlt_o    = en_i & ir_i[RR_HLT];

endmodule

// File: rtl/mano_ctrl_seq.sv
// Instruction sequencer for the 16-bit basic computer: fetch, decode, indirect and execute
// phases, driving one-cycle datapath strobes and holding memory requests until MEM_RDY.
module mano_ctrl_seq
  import mano_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter bit AUTO_RUN = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              START,
  input  logic [DATA_W-1:0] IR,
  input  logic              MEM_RDY,
  output logic              memRD,
  output logic              memWR,
  output logic              wr_sel,
  output logic              arLD,
  output logic [1:0]        ar_sel,
  output logic              arINR,
  output logic              irLD,
  output logic              drLD,
  output logic              drINR,
  output logic              acLD,
  output logic [1:0]        ac_op,
  output logic              pcLD,
  output logic              pcINR,
  output logic              pcCLR,
  output logic              ISZ,
  output logic              SPA,
  output logic              SNA,
  output logic              SZA,
  output logic              SZE,
  output logic [6:0]        rr_ctl,
  output logic              HALTED
);

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;

  logic       mem_rd_q, mem_rd_d;
  logic       mem_wr_q, mem_wr_d;
  logic       wr_sel_q, wr_sel_d;
  logic       ar_ld_q, ar_ld_d;
  logic [1:0] ar_sel_q, ar_sel_d;
  logic       pc_ld_q, pc_ld_d;
  logic       pc_clr_q, pc_clr_d;
  logic       dr_inr_q, dr_inr_d;
  logic       ac_ld_q, ac_ld_d;
  logic [1:0] ac_op_q, ac_op_d;
  logic       halted_q, halted_d;

  logic       hlt;

  // S_CLR holds until its pcCLR strobe has been seen, so the strobe appears the cycle after reset.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_CLR:  if (pc_clr_q) state_d = AUTO_RUN ? S_F0 : S_HALT;
      S_F0:   state_d = S_F1;
      S_F1:   if (MEM_RDY) state_d = S_DEC;
      S_DEC: begin
        op_d = IR[DATA_W-2 -: 3];
        if (op_d == OP_RR) state_d = IR[DATA_W-1] ? S_F0 : S_RR;
        else               state_d = IR[DATA_W-1] ? S_IND : S_EX0;
      end
      S_IND:  if (MEM_RDY) state_d = S_EX0;
      S_EX0: begin
        if (op_q == OP_BUN)     state_d = S_F0;
        else if (op_q == OP_STA) begin
          if (MEM_RDY) state_d = S_F0;
        end else if (MEM_RDY)   state_d = S_EX1;
      end
      S_EX1:  state_d = (op_q == OP_ISZ) ? S_EX2 : S_F0;
      S_EX2:  if (MEM_RDY) state_d = S_F0;
      S_RR:   state_d = hlt ? S_HALT : S_F0;
      S_HALT: if (START) state_d = S_F0;
      default: state_d = S_CLR;
    endcase
  end

  // Moore strobes are decoded from the next state and registered.
  always_comb begin
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    wr_sel_d = WR_SEL_DR;
    ar_ld_d  = 1'b0;
    ar_sel_d = AR_SEL_PC;
    pc_ld_d  = 1'b0;
    pc_clr_d = 1'b0;
    dr_inr_d = 1'b0;
    ac_ld_d  = 1'b0;
    ac_op_d  = AC_OP_AND;
    halted_d = 1'b0;
    case (state_d)
      S_CLR:  pc_clr_d = 1'b1;
      S_F0: begin
        ar_ld_d  = 1'b1;
        ar_sel_d = AR_SEL_PC;
      end
      S_F1:   mem_rd_d = 1'b1;
      S_DEC: begin
        ar_ld_d  = 1'b1;
        ar_sel_d = AR_SEL_IR;
      end
      S_IND: begin
        mem_rd_d = 1'b1;
        ar_sel_d = AR_SEL_BUS;
      end
      S_EX0: begin
        if (reads_operand(op_d)) mem_rd_d = 1'b1;
        else if (op_d == OP_STA) mem_wr_d = 1'b1;
        else if (op_d == OP_BSA) begin
          mem_wr_d = 1'b1;
          wr_sel_d = WR_SEL_PC;
        end else if (op_d == OP_BUN) pc_ld_d = 1'b1;
      end
      S_EX1: begin
        if (op_d == OP_BSA)      pc_ld_d  = 1'b1;
        else if (op_d == OP_ISZ) dr_inr_d = 1'b1;
        else begin
          ac_ld_d = 1'b1;
          ac_op_d = ac_op_of(op_d);
        end
      end
      S_EX2:  mem_wr_d = 1'b1;
      S_HALT: halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_CLR;
      op_q     <= OP_AND;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      wr_sel_q <= WR_SEL_DR;
      ar_ld_q  <= 1'b0;
      ar_sel_q <= AR_SEL_PC;
      pc_ld_q  <= 1'b0;
      pc_clr_q <= 1'b0;
      dr_inr_q <= 1'b0;
      ac_ld_q  <= 1'b0;
      ac_op_q  <= AC_OP_AND;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      wr_sel_q <= wr_sel_d;
      ar_ld_q  <= ar_ld_d;
      ar_sel_q <= ar_sel_d;
      pc_ld_q  <= pc_ld_d;
      pc_clr_q <= pc_clr_d;
      dr_inr_q <= dr_inr_d;
      ac_ld_q  <= ac_ld_d;
      ac_op_q  <= ac_op_d;
      halted_q <= halted_d;
    end
  end

  mano_rr_decode u_rr_decode (
    .en_i     (state_q == S_RR),
    .ir_i     (IR[ADDR_W-1:0]),
    .rr_ctl_o (rr_ctl),
    .spa_o    (SPA),
    .sna_o    (SNA),
    .sza_o    (SZA),
    .sze_o    (SZE),
    .hlt_o    (hlt)
  );

  // Transfer-completion strobes fire only in the cycle the memory acknowledges.
  assign irLD   = (state_q == S_F1) & MEM_RDY;
  assign pcINR  = (state_q == S_F1) & MEM_RDY;
  assign drLD   = (state_q == S_EX0) & reads_operand(op_q) & MEM_RDY;
  assign arINR  = (state_q == S_EX0) & (op_q == OP_BSA) & MEM_RDY;
  assign ISZ    = (state_q == S_EX2) & MEM_RDY;
  assign arLD   = ar_ld_q | ((state_q == S_IND) & MEM_RDY);
  assign ar_sel = arLD ? ar_sel_q : AR_SEL_PC;

  assign memRD  = mem_rd_q;
  assign memWR  = mem_wr_q;
  assign wr_sel = wr_sel_q;
  assign pcLD   = pc_ld_q;
  assign pcCLR  = pc_clr_q;
  assign drINR  = dr_inr_q;
  assign acLD   = ac_ld_q;
  assign ac_op  = ac_op_q;
  assign HALTED = halted_q;

endmodule

// File: tb/tb_mano_ctrl_seq.sv
// Directed bench for mano_ctrl_seq: steps through each instruction class cycle by cycle
// and compares the full strobe bundle against hand-derived expectations.
module tb_mano_ctrl_seq;

  typedef struct packed {
    logic       memRD;
    logic       memWR;
    logic       wr_sel;
    logic       arLD;
    logic [1:0] ar_sel;
    logic       arINR;
    logic       irLD;
    logic       drLD;
    logic       drINR;
    logic       acLD;
    logic [1:0] ac_op;
    logic       pcLD;
    logic       pcINR;
    logic       pcCLR;
    logic       ISZ;
    logic       SPA;
    logic       SNA;
    logic       SZA;
    logic       SZE;
    logic [6:0] rr_ctl;
    logic       HALTED;
  } outs_t;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        START;
  logic [15:0] IR;
  logic        MEM_RDY;
  logic        memRD, memWR, wr_sel, arLD, arINR, irLD, drLD, drINR, acLD;
  logic        pcLD, pcINR, pcCLR, ISZ, SPA, SNA, SZA, SZE, HALTED;
  logic [1:0]  ar_sel, ac_op;
  logic [6:0]  rr_ctl;
  outs_t       outs;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mano_ctrl_seq #(.ADDR_W(12), .DATA_W(16), .AUTO_RUN(1'b1)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .IR(IR), .MEM_RDY(MEM_RDY),
    .memRD(memRD), .memWR(memWR), .wr_sel(wr_sel), .arLD(arLD), .ar_sel(ar_sel),
    .arINR(arINR), .irLD(irLD), .drLD(drLD), .drINR(drINR), .acLD(acLD), .ac_op(ac_op),
    .pcLD(pcLD), .pcINR(pcINR), .pcCLR(pcCLR), .ISZ(ISZ), .SPA(SPA), .SNA(SNA),
    .SZA(SZA), .SZE(SZE), .rr_ctl(rr_ctl), .HALTED(HALTED)
  );

  assign outs = {memRD, memWR, wr_sel, arLD, ar_sel, arINR, irLD, drLD, drINR, acLD,
                 ac_op, pcLD, pcINR, pcCLR, ISZ, SPA, SNA, SZA, SZE, rr_ctl, HALTED};

  function automatic outs_t e_none();
    outs_t e = '0;
    return e;
  endfunction

  function automatic outs_t e_clr();
    outs_t e = '0;
    e.pcCLR = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_f0();
    outs_t e = '0;
    e.arLD = 1'b1;
    e.ar_sel = 2'd0;
    return e;
  endfunction

  function automatic outs_t e_f1(input logic rdy);
    outs_t e = '0;
    e.memRD = 1'b1;
    e.irLD  = rdy;
    e.pcINR = rdy;
    return e;
  endfunction

  function automatic outs_t e_dec();
    outs_t e = '0;
    e.arLD = 1'b1;
    e.ar_sel = 2'd1;
    return e;
  endfunction

  function automatic outs_t e_ind(input logic rdy);
    outs_t e = '0;
    e.memRD = 1'b1;
    e.arLD  = rdy;
    e.ar_sel = rdy ? 2'd2 : 2'd0;
    return e;
  endfunction

  function automatic outs_t e_rd(input logic rdy);
    outs_t e = '0;
    e.memRD = 1'b1;
    e.drLD  = rdy;
    return e;
  endfunction

  function automatic outs_t e_ac(input logic [1:0] op);
    outs_t e = '0;
    e.acLD = 1'b1;
    e.ac_op = op;
    return e;
  endfunction

  function automatic outs_t e_wr(input logic sel, input logic ar_inr, input logic isz);
    outs_t e = '0;
    e.memWR  = 1'b1;
    e.wr_sel = sel;
    e.arINR  = ar_inr;
    e.ISZ    = isz;
    return e;
  endfunction

  function automatic outs_t e_pcld();
    outs_t e = '0;
    e.pcLD = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_drinr();
    outs_t e = '0;
    e.drINR = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_rr(input logic [6:0] ctl, input logic [3:0] skip);
    outs_t e = '0;
    e.rr_ctl = ctl;
    {e.SPA, e.SNA, e.SZA, e.SZE} = skip;
    return e;
  endfunction

  function automatic outs_t e_halt();
    outs_t e = '0;
    e.HALTED = 1'b1;
    return e;
  endfunction

  task automatic check(input string tag, input outs_t e);
    n_assert++;
    assert (outs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, outs, e);
    end
  endtask

  // One clock: drive this cycle's inputs just after the edge, then compare mid-cycle.
  task automatic step(input string tag, input logic rdy, input logic [15:0] ir, input outs_t e);
    @(posedge CLK);
    #1;
    MEM_RDY = rdy;
    IR      = ir;
    #1;
    check(tag, e);
  endtask

  initial begin
    RSTn    = 1'b0;
    START   = 1'b0;
    IR      = 16'h0000;
    MEM_RDY = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    check("reset_all_zero", e_none());
    RSTn = 1'b1;

    // Power-up and ADD direct with memory always ready
    step("clr_cycle1",   1'b1, 16'h1055, e_clr());
    step("f0_cycle2",    1'b1, 16'h1055, e_f0());
    step("f1_cycle3",    1'b1, 16'h1055, e_f1(1'b1));
    step("add_dec",      1'b1, 16'h1055, e_dec());
    step("add_ex0",      1'b1, 16'h1055, e_rd(1'b1));
    step("add_ex1",      1'b1, 16'h1055, e_ac(2'd1));
    step("add_done_f0",  1'b1, 16'h8123, e_f0());

    // AND indirect, stalled fetch and stalled indirect read
    step("and_f1_wait0", 1'b0, 16'h8123, e_f1(1'b0));
    step("and_f1_wait1", 1'b0, 16'h8123, e_f1(1'b0));
    step("and_f1_rdy",   1'b1, 16'h8123, e_f1(1'b1));
    step("and_dec",      1'b1, 16'h8123, e_dec());
    step("and_ind_w0",   1'b0, 16'h8123, e_ind(1'b0));
    step("and_ind_w1",   1'b0, 16'h8123, e_ind(1'b0));
    step("and_ind_w2",   1'b0, 16'h8123, e_ind(1'b0));
    step("and_ind_rdy",  1'b1, 16'h8123, e_ind(1'b1));
    step("and_ex0",      1'b1, 16'h8123, e_rd(1'b1));
    step("and_ex1",      1'b1, 16'h8123, e_ac(2'd0));
    step("and_done_f0",  1'b1, 16'h6040, e_f0());

    // ISZ with one write stall in the write-back phase
    step("isz_f1",       1'b1, 16'h6040, e_f1(1'b1));
    step("isz_dec",      1'b1, 16'h6040, e_dec());
    step("isz_ex0",      1'b1, 16'h6040, e_rd(1'b1));
    step("isz_ex1",      1'b1, 16'h6040, e_drinr());
    step("isz_ex2_wait", 1'b0, 16'h6040, e_wr(1'b0, 1'b0, 1'b0));
    step("isz_ex2_rdy",  1'b1, 16'h6040, e_wr(1'b0, 1'b0, 1'b1));
    step("isz_done_f0",  1'b1, 16'h5020, e_f0());

    // BSA
    step("bsa_f1",       1'b1, 16'h5020, e_f1(1'b1));
    step("bsa_dec",      1'b1, 16'h5020, e_dec());
    step("bsa_ex0",      1'b1, 16'h5020, e_wr(1'b1, 1'b1, 1'b0));
    step("bsa_ex1",      1'b1, 16'h5020, e_pcld());
    step("bsa_done_f0",  1'b1, 16'h3010, e_f0());

    // STA with a write stall
    step("sta_f1",       1'b1, 16'h3010, e_f1(1'b1));
    step("sta_dec",      1'b1, 16'h3010, e_dec());
    step("sta_ex0_wait", 1'b0, 16'h3010, e_wr(1'b0, 1'b0, 1'b0));
    step("sta_ex0_rdy",  1'b1, 16'h3010, e_wr(1'b0, 1'b0, 1'b0));
    step("sta_done_f0",  1'b1, 16'h4100, e_f0());

    // BUN
    step("bun_f1",       1'b1, 16'h4100, e_f1(1'b1));
    step("bun_dec",      1'b1, 16'h4100, e_dec());
    step("bun_ex0",      1'b1, 16'h4100, e_pcld());
    step("bun_done_f0",  1'b1, 16'hF200, e_f0());

    // I/O word executes as NOP
    step("io_f1",        1'b1, 16'hF200, e_f1(1'b1));
    step("io_dec",       1'b1, 16'hF200, e_dec());
    step("io_done_f0",   1'b1, 16'h7840, e_f0());

    // Register reference: CLA+CIL together, then SPA+SZA together
    step("cla_f1",       1'b1, 16'h7840, e_f1(1'b1));
    step("cla_dec",      1'b1, 16'h7840, e_dec());
    step("cla_cil_rr",   1'b1, 16'h7840, e_rr(7'b1000010, 4'b0000));
    step("cla_done_f0",  1'b1, 16'h7014, e_f0());
    step("skip_f1",      1'b1, 16'h7014, e_f1(1'b1));
    step("skip_dec",     1'b1, 16'h7014, e_dec());
    step("spa_sza_rr",   1'b1, 16'h7014, e_rr(7'b0000000, 4'b1010));
    step("skip_done_f0", 1'b1, 16'h7001, e_f0());

    // HLT, MEM_RDY ignored while halted, START resumes
    step("hlt_f1",       1'b1, 16'h7001, e_f1(1'b1));
    step("hlt_dec",      1'b1, 16'h7001, e_dec());
    step("hlt_rr",       1'b1, 16'h7001, e_none());
    step("halted_0",     1'b1, 16'h7001, e_halt());
    step("halted_1",     1'b1, 16'h7001, e_halt());
    START = 1'b1;
    step("start_f0",     1'b1, 16'h2005, e_f0());
    START = 1'b0;

    // LDA interrupted by reset during its operand read
    step("lda_f1",       1'b1, 16'h2005, e_f1(1'b1));
    step("lda_dec",      1'b1, 16'h2005, e_dec());
    step("lda_ex0_wait", 1'b0, 16'h2005, e_rd(1'b0));
    RSTn = 1'b0;
    #1;
    check("reset_mid_ex0", e_none());
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    step("restart_clr",  1'b1, 16'h2005, e_clr());
    step("restart_f0",   1'b1, 16'h2005, e_f0());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
